// File: rtl/trap_controller.sv
// trap_controller
// Sequences trap entry and mret return for the single-issue core.
// Exceptions and enabled machine interrupts are arbitrated in IDLE.
// An accepted trap spends one cycle in COMMIT, driving the mepc/mcause
// write strobe, then one cycle in REDIRECT, steering fetch to mtvec.
// An accepted mret goes straight to REDIRECT and steers fetch to mepc.
//
// Build option: define VECTORED_MTVEC_EN to vector interrupts to
// base + 4*cause when mtvec[1:0] == 2'b01. Exceptions always go to base.
// Without the macro, mtvec[1:0] is ignored.

module trap_controller #(
  parameter int XLEN    = 32,
  parameter int NUM_EXC = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] cur_pc,
  input  logic [NUM_EXC-1:0] exc_req,
  input  logic            irq_ext,
  input  logic            irq_soft,
  input  logic            irq_timer,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            mret_req,
  output logic            exception_asserted,
  output logic [XLEN-1:0] exception_mepc,
  output logic [XLEN-1:0] exception_mcause,
  output logic            stall,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            in_trap
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  // Exception request line index -> mcause code. Lower index wins.
  function automatic logic [4:0] exc_code_lut(input int idx);
    case (idx)
      0:       exc_code_lut = 5'd0;   // instruction address misaligned
      1:       exc_code_lut = 5'd2;   // illegal instruction
      2:       exc_code_lut = 5'd3;   // breakpoint
      3:       exc_code_lut = 5'd11;  // ecall from M-mode
      4:       exc_code_lut = 5'd4;   // load address misaligned
      5:       exc_code_lut = 5'd6;   // store address misaligned
      default: exc_code_lut = 5'd0;
    endcase
  endfunction

  state_t          state_reg;
  logic            in_trap_reg;
  logic            is_mret_reg;
  logic [XLEN-1:0] target_reg;
  logic            exception_asserted_reg;
  logic [XLEN-1:0] exception_mepc_reg;
  logic [XLEN-1:0] exception_mcause_reg;
  logic            flush_reg;
  logic            redirect_valid_reg;
  logic [XLEN-1:0] redirect_pc_reg;

  logic [NUM_EXC-1:0] exc_first;
  logic [4:0]         exc_code_term [NUM_EXC];
  logic               exc_hit;
  logic [4:0]         exc_code;

  logic               irq_ext_en;
  logic               irq_soft_en;
  logic               irq_timer_en;
  logic               irq_pending;
  logic [4:0]         irq_code;

  logic [XLEN-1:0]    trap_cause;
  logic [XLEN-1:0]    trap_base;
  logic [XLEN-1:0]    trap_target;
  logic               take_trap;
  logic               take_mret;

  // Only mie bits 11/7/3 matter; the remaining bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{mie[XLEN-1:12], mie[10:8], mie[6:4], mie[2:0], mtvec[1:0]};

  // One-hot of the highest-priority exception line and its cause code.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_EXC; gi++) begin : g_exc
      logic lower_clear;
      if (gi == 0) begin : g_first
        assign lower_clear = 1'b1;
      end else begin : g_rest
        assign lower_clear = ~|exc_req[gi-1:0];
      end
      assign exc_first[gi]     = exc_req[gi] & lower_clear;
      assign exc_code_term[gi] = exc_first[gi] ? exc_code_lut(gi) : 5'd0;
    end
  endgenerate

  assign exc_hit = |exc_req;

  // Merge the per-line codes; at most one term is non-zero.
  always_comb begin
    exc_code = 5'd0;
    for (int i = 0; i < NUM_EXC; i++) begin
      exc_code = exc_code | exc_code_term[i];
    end
  end

  assign irq_ext_en   = irq_ext   & mie[11];
  assign irq_soft_en  = irq_soft  & mie[3];
  assign irq_timer_en = irq_timer & mie[7];
  assign irq_pending  = mstatus_mie & ~in_trap_reg & (irq_ext_en | irq_soft_en | irq_timer_en);

  // Interrupt priority: external, then software, then timer.
  always_comb begin
    irq_code = 5'd0;
    if (irq_ext_en) begin
      irq_code = 5'd11;
    end else if (irq_soft_en) begin
      irq_code = 5'd3;
    end else if (irq_timer_en) begin
      irq_code = 5'd7;
    end
  end

  assign trap_cause = exc_hit ? {1'b0, {(XLEN-6){1'b0}}, exc_code}
                              : {1'b1, {(XLEN-6){1'b0}}, irq_code};

  assign trap_base = {mtvec[XLEN-1:2], 2'b00};

  // Handler address, captured at acceptance so mtvec can change afterwards.
  always_comb begin
    trap_target = trap_base;
`ifdef VECTORED_MTVEC_EN
    if (!exc_hit && (mtvec[1:0] == 2'b01)) begin
      trap_target = trap_base + {{(XLEN-7){1'b0}}, irq_code, 2'b00};
    end
`endif
  end

  // Exceptions beat interrupts, both beat mret; nothing is taken without inst_valid.
  assign take_trap = inst_valid & (exc_hit | irq_pending);
  assign take_mret = inst_valid & ~exc_hit & ~irq_pending & mret_req;

  // Trap sequencer: IDLE -> COMMIT -> REDIRECT -> IDLE, or IDLE -> REDIRECT for mret.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg              <= IDLE;
      in_trap_reg            <= 1'b0;
      is_mret_reg            <= 1'b0;
      target_reg             <= '0;
      exception_asserted_reg <= 1'b0;
      exception_mepc_reg     <= '0;
      exception_mcause_reg   <= '0;
      flush_reg              <= 1'b0;
      redirect_valid_reg     <= 1'b0;
      redirect_pc_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          exception_asserted_reg <= 1'b0;
          redirect_valid_reg     <= 1'b0;
          flush_reg              <= 1'b0;
          if (take_trap) begin
            state_reg              <= COMMIT;
            exception_asserted_reg <= 1'b1;
            exception_mepc_reg     <= cur_pc;
            exception_mcause_reg   <= trap_cause;
            target_reg             <= trap_target;
            is_mret_reg            <= 1'b0;
            flush_reg              <= 1'b1;
          end else if (take_mret) begin
            state_reg          <= REDIRECT;
            redirect_valid_reg <= 1'b1;
            redirect_pc_reg    <= {mepc[XLEN-1:2], 2'b00};
            is_mret_reg        <= 1'b1;
            flush_reg          <= 1'b1;
          end
        end
        COMMIT: begin
          state_reg              <= REDIRECT;
          exception_asserted_reg <= 1'b0;
          in_trap_reg            <= 1'b1;
          redirect_valid_reg     <= 1'b1;
          redirect_pc_reg        <= target_reg;
          flush_reg              <= 1'b1;
        end
        REDIRECT: begin
          state_reg          <= IDLE;
          redirect_valid_reg <= 1'b0;
          flush_reg          <= 1'b0;
          if (is_mret_reg) begin
            in_trap_reg <= 1'b0;
          end
          is_mret_reg <= 1'b0;
        end
        default: begin
          state_reg              <= IDLE;
          exception_asserted_reg <= 1'b0;
          redirect_valid_reg     <= 1'b0;
          flush_reg              <= 1'b0;
        end
      endcase
    end
  end

  assign stall              = (state_reg == COMMIT);
  assign exception_asserted = exception_asserted_reg;
  assign exception_mepc     = exception_mepc_reg;
  assign exception_mcause   = exception_mcause_reg;
  assign flush              = flush_reg;
  assign redirect_valid     = redirect_valid_reg;
  assign redirect_pc        = redirect_pc_reg;
  assign in_trap            = in_trap_reg;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: a vector table, hand sequences for reset
// and mtvec vectoring, then randomized requests against a reference model.
// Build option VECTORED_MTVEC_EN is mirrored here.

module tb_trap_controller;

  localparam int XLEN = 32;
  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_TRAP = 2'd1;
  localparam logic [1:0] K_MRET = 2'd2;

  logic            clock;
  logic            reset;
  logic            inst_valid;
  logic [XLEN-1:0] cur_pc;
  logic [5:0]      exc_req;
  logic            irq_ext, irq_soft, irq_timer;
  logic            mstatus_mie;
  logic [XLEN-1:0] mie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            mret_req;
  logic            exception_asserted;
  logic [XLEN-1:0] exception_mepc;
  logic [XLEN-1:0] exception_mcause;
  logic            stall;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            in_trap;

  trap_controller #(.XLEN(XLEN), .NUM_EXC(6)) dut (
    .clock(clock), .reset(reset), .inst_valid(inst_valid), .cur_pc(cur_pc),
    .exc_req(exc_req), .irq_ext(irq_ext), .irq_soft(irq_soft), .irq_timer(irq_timer),
    .mstatus_mie(mstatus_mie), .mie(mie), .mtvec(mtvec), .mepc(mepc),
    .mret_req(mret_req), .exception_asserted(exception_asserted),
    .exception_mepc(exception_mepc), .exception_mcause(exception_mcause),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .in_trap(in_trap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        valid;
    logic [5:0]  exc;
    logic [2:0]  irq;     // {ext, soft, timer}
    logic [31:0] mie_v;
    logic        mst;
    logic        mret;
    logic [31:0] pc;
    logic [31:0] mepc_v;
    logic [31:0] mtvec_v;
    logic [1:0]  kind;
    logic [31:0] cause;
    logic [31:0] target;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_in_trap = 1'b0;
  vec_t tbl [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic [5:0] exc, input logic [2:0] irq,
                              input logic [31:0] mie_v, input logic mst, input logic mret,
                              input logic [31:0] pc, input logic [31:0] mepc_v,
                              input logic [31:0] mtvec_v, input logic [1:0] kind,
                              input logic [31:0] cause, input logic [31:0] target);
    vec_t v;
    v.valid = valid; v.exc = exc; v.irq = irq; v.mie_v = mie_v; v.mst = mst;
    v.mret = mret; v.pc = pc; v.mepc_v = mepc_v; v.mtvec_v = mtvec_v;
    v.kind = kind; v.cause = cause; v.target = target;
    return v;
  endfunction

  // Reference: decide what the architecture takes for one request.
  function automatic vec_t model(input vec_t v, input logic cur_in_trap);
    int          codes [6] = '{0, 2, 3, 11, 4, 6};
    vec_t        r = v;
    int          code = -1;
    logic        is_irq = 1'b0;
    logic [31:0] base = {v.mtvec_v[31:2], 2'b00};
    r.kind = K_NONE; r.cause = 0; r.target = 0;
    if (v.valid) begin
      for (int i = 5; i >= 0; i--) if (v.exc[i]) code = codes[i];
      if (code < 0 && v.mst && !cur_in_trap) begin
        if (v.irq[2] && v.mie_v[11])     code = 11;
        else if (v.irq[1] && v.mie_v[3]) code = 3;
        else if (v.irq[0] && v.mie_v[7]) code = 7;
        is_irq = (code >= 0);
      end
      if (code >= 0) begin
        r.kind   = K_TRAP;
        r.cause  = (is_irq ? 32'h8000_0000 : 32'h0) + 32'(code);
        r.target = base;
`ifdef VECTORED_MTVEC_EN
        if (is_irq && v.mtvec_v[1:0] == 2'b01) r.target = base + 32'(4 * code);
`endif
      end else if (v.mret) begin
        r.kind   = K_MRET;
        r.target = {v.mepc_v[31:2], 2'b00};
      end
    end
    return r;
  endfunction

  task automatic quiet();
    inst_valid = 1'b0; exc_req = '0; mret_req = 1'b0;
    irq_ext = 1'b0; irq_soft = 1'b0; irq_timer = 1'b0;
  endtask

  // Garbage on request lines while busy; it must be ignored.
  task automatic junk();
    inst_valid = 1'b1; exc_req = 6'($urandom); mret_req = 1'($urandom);
    irq_ext = 1'($urandom); irq_soft = 1'($urandom); irq_timer = 1'($urandom);
    mepc = $urandom;
  endtask

  // Apply one request from IDLE and check every cycle of its response.
  task automatic do_txn(input vec_t v, input string tag);
    inst_valid = v.valid; exc_req = v.exc;
    irq_ext = v.irq[2]; irq_soft = v.irq[1]; irq_timer = v.irq[0];
    mie = v.mie_v; mstatus_mie = v.mst; mret_req = v.mret;
    cur_pc = v.pc; mepc = v.mepc_v; mtvec = v.mtvec_v;
    @(posedge clock); #1;
    $display("txn %s kind=%0d cause=%h target=%h", tag, v.kind, v.cause, v.target);
    if (v.kind == K_TRAP) begin
      junk();
      chk({tag, " commit.exc_asserted"}, 32'(exception_asserted), 32'd1);
      chk({tag, " commit.mepc"}, exception_mepc, v.pc);
      chk({tag, " commit.mcause"}, exception_mcause, v.cause);
      chk({tag, " commit.stall"}, 32'(stall), 32'd1);
      chk({tag, " commit.flush"}, 32'(flush), 32'd1);
      chk({tag, " commit.redirect_valid"}, 32'(redirect_valid), 32'd0);
      @(posedge clock); #1;
      chk({tag, " redir.redirect_valid"}, 32'(redirect_valid), 32'd1);
      chk({tag, " redir.redirect_pc"}, redirect_pc, v.target);
      chk({tag, " redir.in_trap"}, 32'(in_trap), 32'd1);
      chk({tag, " redir.exc_asserted"}, 32'(exception_asserted), 32'd0);
      chk({tag, " redir.stall"}, 32'(stall), 32'd0);
      chk({tag, " redir.flush"}, 32'(flush), 32'd1);
      m_in_trap = 1'b1;
      @(posedge clock); #1;
      quiet();
    end else if (v.kind == K_MRET) begin
      junk();
      chk({tag, " mret.redirect_valid"}, 32'(redirect_valid), 32'd1);
      chk({tag, " mret.redirect_pc"}, redirect_pc, v.target);
      chk({tag, " mret.exc_asserted"}, 32'(exception_asserted), 32'd0);
      chk({tag, " mret.stall"}, 32'(stall), 32'd0);
      chk({tag, " mret.flush"}, 32'(flush), 32'd1);
      m_in_trap = 1'b0;
      @(posedge clock); #1;
      quiet();
    end else begin
      quiet();
    end
    chk({tag, " idle.exc_asserted"}, 32'(exception_asserted), 32'd0);
    chk({tag, " idle.redirect_valid"}, 32'(redirect_valid), 32'd0);
    chk({tag, " idle.stall"}, 32'(stall), 32'd0);
    chk({tag, " idle.flush"}, 32'(flush), 32'd0);
    chk({tag, " idle.in_trap"}, 32'(in_trap), 32'(m_in_trap));
  endtask

  initial begin
    vec_t v;
    // valid exc irq mie mst mret pc mepc mtvec | kind cause target
    tbl[0]  = mk(1, 6'h02, 3'b000, 32'h000, 0, 0, 32'h100, 32'h0,   32'h800,  K_TRAP, 32'h2, 32'h800);
    tbl[1]  = mk(1, 6'h00, 3'b000, 32'h000, 0, 1, 32'h104, 32'h204, 32'h800,  K_MRET, 32'h0, 32'h204);
    tbl[2]  = mk(1, 6'h0C, 3'b000, 32'h000, 0, 0, 32'h104, 32'h0,   32'h800,  K_TRAP, 32'h3, 32'h800);
    tbl[3]  = mk(1, 6'h00, 3'b000, 32'h000, 0, 1, 32'h108, 32'h107, 32'h800,  K_MRET, 32'h0, 32'h104);
    tbl[4]  = mk(1, 6'h02, 3'b001, 32'h080, 1, 0, 32'h108, 32'h0,   32'h800,  K_TRAP, 32'h2, 32'h800);
    tbl[5]  = mk(1, 6'h00, 3'b000, 32'h000, 0, 1, 32'h10C, 32'h300, 32'h800,  K_MRET, 32'h0, 32'h300);
    tbl[6]  = mk(1, 6'h00, 3'b001, 32'h080, 1, 0, 32'h200, 32'h0,   32'h800,  K_TRAP, 32'h8000_0007, 32'h800);
    tbl[7]  = mk(1, 6'h00, 3'b001, 32'h080, 1, 0, 32'h204, 32'h0,   32'h800,  K_NONE, 32'h0, 32'h0);
    tbl[8]  = mk(1, 6'h20, 3'b000, 32'h000, 0, 1, 32'h208, 32'h500, 32'h800,  K_TRAP, 32'h6, 32'h800);
    tbl[9]  = mk(1, 6'h00, 3'b000, 32'h000, 0, 1, 32'h20C, 32'h204, 32'h800,  K_MRET, 32'h0, 32'h204);
    tbl[10] = mk(1, 6'h00, 3'b100, 32'h800, 1, 0, 32'h210, 32'h0,   32'h800,  K_TRAP, 32'h8000_000B, 32'h800);
    tbl[11] = mk(1, 6'h00, 3'b000, 32'h000, 0, 1, 32'h214, 32'h214, 32'h800,  K_MRET, 32'h0, 32'h214);
    tbl[12] = mk(1, 6'h00, 3'b111, 32'h888, 1, 0, 32'h218, 32'h0,   32'h1003, K_TRAP, 32'h8000_000B, 32'h1000);
    tbl[13] = mk(1, 6'h00, 3'b000, 32'h000, 0, 1, 32'h21C, 32'h21C, 32'h800,  K_MRET, 32'h0, 32'h21C);
    tbl[14] = mk(1, 6'h00, 3'b011, 32'h888, 1, 0, 32'h220, 32'h0,   32'h800,  K_TRAP, 32'h8000_0003, 32'h800);
    tbl[15] = mk(1, 6'h00, 3'b000, 32'h000, 0, 1, 32'h224, 32'h224, 32'h800,  K_MRET, 32'h0, 32'h224);
    tbl[16] = mk(1, 6'h00, 3'b001, 32'h080, 0, 0, 32'h228, 32'h0,   32'h800,  K_NONE, 32'h0, 32'h0);
    tbl[17] = mk(1, 6'h00, 3'b100, 32'h088, 1, 0, 32'h228, 32'h0,   32'h800,  K_NONE, 32'h0, 32'h0);
    tbl[18] = mk(1, 6'h3F, 3'b111, 32'h888, 1, 1, 32'h22C, 32'h0,   32'h800,  K_TRAP, 32'h0, 32'h800);
    tbl[19] = mk(1, 6'h30, 3'b000, 32'h000, 0, 0, 32'h230, 32'h0,   32'h800,  K_TRAP, 32'h4, 32'h800);
    tbl[20] = mk(1, 6'h08, 3'b000, 32'h000, 0, 0, 32'h234, 32'h0,   32'h800,  K_TRAP, 32'hB, 32'h800);
    tbl[21] = mk(1, 6'h00, 3'b000, 32'h000, 0, 1, 32'h238, 32'h238, 32'h800,  K_MRET, 32'h0, 32'h238);
    tbl[22] = mk(0, 6'h02, 3'b111, 32'h888, 1, 1, 32'h23C, 32'h0,   32'h800,  K_NONE, 32'h0, 32'h0);
    tbl[23] = mk(1, 6'h00, 3'b000, 32'h888, 1, 0, 32'h240, 32'h0,   32'h800,  K_NONE, 32'h0, 32'h0);

    quiet();
    cur_pc = 0; mie = 0; mtvec = 0; mepc = 0; mstatus_mie = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset.exc_asserted", 32'(exception_asserted), 32'd0);
    chk("reset.mepc", exception_mepc, 32'd0);
    chk("reset.mcause", exception_mcause, 32'd0);
    chk("reset.stall", 32'(stall), 32'd0);
    chk("reset.flush", 32'(flush), 32'd0);
    chk("reset.redirect_valid", 32'(redirect_valid), 32'd0);
    chk("reset.redirect_pc", redirect_pc, 32'd0);
    chk("reset.in_trap", 32'(in_trap), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) do_txn(tbl[i], $sformatf("tbl%0d", i));

    // Reset while in COMMIT abandons the trap.
    inst_valid = 1'b1; exc_req = 6'h02; cur_pc = 32'h400; mtvec = 32'h800;
    @(posedge clock); #1;
    $display("txn reset_in_commit");
    quiet();
    chk("rstc.commit_seen", 32'(exception_asserted), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rstc.exc_asserted", 32'(exception_asserted), 32'd0);
    chk("rstc.mepc", exception_mepc, 32'd0);
    chk("rstc.mcause", exception_mcause, 32'd0);
    chk("rstc.redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rstc.redirect_pc", redirect_pc, 32'd0);
    chk("rstc.stall", 32'(stall), 32'd0);
    chk("rstc.flush", 32'(flush), 32'd0);
    chk("rstc.in_trap", 32'(in_trap), 32'd0);
    @(posedge clock); #1;
    chk("rstc.no_redirect_later", 32'(redirect_valid), 32'd0);
    m_in_trap = 1'b0;

    // mtvec vectoring of interrupts.
`ifdef VECTORED_MTVEC_EN
    do_txn(mk(1, 6'h00, 3'b010, 32'h008, 1, 0, 32'h500, 32'h0, 32'h801, K_TRAP, 32'h8000_0003, 32'h80C), "vec_soft");
    do_txn(mk(1, 6'h00, 3'b000, 32'h000, 0, 1, 32'h504, 32'h504, 32'h801, K_MRET, 32'h0, 32'h504), "vec_mret");
    do_txn(mk(1, 6'h02, 3'b000, 32'h000, 0, 0, 32'h508, 32'h0, 32'h801, K_TRAP, 32'h2, 32'h800), "vec_illegal");
`else
    do_txn(mk(1, 6'h00, 3'b010, 32'h008, 1, 0, 32'h500, 32'h0, 32'h801, K_TRAP, 32'h8000_0003, 32'h800), "novec_soft");
    do_txn(mk(1, 6'h00, 3'b000, 32'h000, 0, 1, 32'h504, 32'h504, 32'h801, K_MRET, 32'h0, 32'h504), "novec_mret");
`endif

    // Randomized requests checked against the reference model.
    for (int n = 0; n < 200; n++) begin
      v.valid   = ($urandom_range(0, 7) != 0);
      v.exc     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0;
      v.irq     = 3'($urandom);
      v.mie_v   = $urandom & 32'h0000_0888;
      v.mst     = 1'($urandom);
      v.mret    = 1'($urandom);
      v.pc      = $urandom;
      v.mepc_v  = $urandom;
      v.mtvec_v = $urandom;
      v.kind = K_NONE; v.cause = 0; v.target = 0;
      v = model(v, m_in_trap);
      do_txn(v, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
Sequences trap entry and return for the single-issue core. Each cycle it arbitrates synchronous exceptions and enabled machine interrupts. It drives the CSR regfile exception write port (mepc/mcause), stalls and flushes the pipeline, and redirects the PC to mtvec on a trap or to mepc on mret. It sits between the execute stage, the CSR regfile and the fetch PC mux.

Parameters:
XLEN, 32, data/address width
NUM_EXC, 6, number of exception request lines (bit map fixed below)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
inst_valid  in  1  instruction in execute stage is valid
cur_pc  in  XLEN  pc of instruction in execute stage
exc_req  in  NUM_EXC  [0] inst_misaligned, [1] illegal, [2] ebreak, [3] ecall_m, [4] load_misaligned, [5] store_misaligned
irq_ext, irq_soft, irq_timer  in  1 each  level interrupt requests
mstatus_mie  in  1  global interrupt enable (mstatus[3])
mie  in  XLEN  mie CSR value; bits 11/3/7 used
mtvec  in  XLEN  mtvec CSR value
mepc  in  XLEN  mepc CSR value
mret_req  in  1  mret in execute stage
exception_asserted  out  1  CSR regfile write strobe for mepc/mcause
exception_mepc  out  XLEN  value written to mepc
exception_mcause  out  XLEN  value written to mcause
stall  out  1  freeze pipeline upstream of execute
flush  out  1  kill instructions in fetch/decode/execute
redirect_valid  out  1  load redirect_pc into fetch PC
redirect_pc  out  XLEN  target pc
in_trap  out  1  handler active; interrupts masked

Behaviour:
- Reset: state=IDLE, in_trap=0, all outputs 0.
- States: IDLE, COMMIT, REDIRECT.
- IDLE: a request is sampled only when inst_valid=1.
  - Any exc_req bit set -> latch cause and cur_pc, go to COMMIT.
  - Else an interrupt is pending if mstatus_mie && !in_trap && (irq_x & mie[bit]) -> latch cause and cur_pc, go to COMMIT.
  - Else mret_req -> latch mepc as target, go to REDIRECT. mret uses no CSR write.
- Exception priority, high to low, with mcause: inst_misaligned=0, illegal=2, ebreak=3, ecall_m=11, load_misaligned=4, store_misaligned=6.
- Interrupt priority, high to low: ext (cause 11), soft (3), timer (7). mcause bit31=1 for interrupts.
- Exceptions beat interrupts. Exceptions and interrupts beat mret; a concurrent mret is dropped, the flush kills it.
- COMMIT, exactly 1 cycle:
  - exception_asserted=1, exception_mepc=latched pc, exception_mcause=latched cause.
  - stall=1, flush=1, in_trap<=1.
  - Next state REDIRECT.
- REDIRECT, exactly 1 cycle:
  - redirect_valid=1, flush=1, stall=0.
  - Trap target: {mtvec[XLEN-1:2],2'b00}, vectoring per the optional feature.
  - mret target: latched mepc with bits[1:0] cleared; in_trap<=0.
  - Next state IDLE.
- Latency: request accepted at cycle N -> exception_asserted at N+1 -> redirect_valid at N+2. mret: accepted at N -> redirect_valid at N+1.
- Outside COMMIT/REDIRECT, stall and flush are 0. Requests arriving in COMMIT/REDIRECT are ignored; the pipeline is flushed.
- Exceptions are taken while in_trap=1 (nested trap overwrites mepc/mcause). Interrupts are not.
- Interrupt lines are level; no latching happens in IDLE until accepted.
- Reset asserted in any state -> IDLE next cycle. A partial trap is abandoned: no exception_asserted, no redirect.
- All outputs registered from the state/latch registers except stall, which is a state decode.

Optional Feature:
VECTORED_MTVEC_EN
- Defined: if mtvec[1:0]==2'b01 and the trap is an interrupt, redirect_pc = base + 4*cause. Exceptions always go to base.
- Undefined: mtvec[1:0] is ignored; all traps go to base.

Test Plan:
- exc_req=6'b000010, cur_pc=0x100, mtvec=0x800 -> N+1: exception_asserted=1, mepc=0x100, mcause=2. N+2: redirect_valid=1, redirect_pc=0x800, in_trap=1.
- exc_req=6'b001100 (ebreak+ecall) -> mcause=3.
- Same cycle as a pending irq_timer -> exception wins, mcause=2 or 3 per request, no interrupt taken.
- irq_timer=1, mie[7]=1, mstatus_mie=1, cur_pc=0x200 -> mcause=0x80000007, mepc=0x200. irq_timer held afterwards -> no re-entry while in_trap=1.
- mret_req with mepc=0x204 after a trap -> redirect_pc=0x204 one cycle later, in_trap=0, no exception_asserted. Then pending irq_ext (mie[11]=1) -> mcause=0x8000000B.
- VECTORED_MTVEC_EN defined, mtvec=0x801, irq_soft -> redirect_pc=0x80C. Illegal exception with same mtvec -> redirect_pc=0x800.
- Reset asserted in COMMIT -> next cycle all outputs 0, state IDLE, no redirect_valid.
